udp_stream_scheduler: RTL
=========================

Name: udp_stream_scheduler

Overview:
- Round-robin scheduler that shares one UDP/IPv4 transmit stack between NUM_CH SDR stream sources (e.g. per-DDC-channel packetisers).
- For each packet it arbitrates a requester, latches its length and port, and performs the app_valid/app_ready handshake with the stack.
- It muxes the winning channel's data into the stack, then waits for the stack to return idle before granting again.
- Sits between the channel packetisers and the UDP/IP stack.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DATA_WIDTH, 32, data word width, matches the stack.
- MAX_LEN, 1472, largest legal payload in bytes.
- TIMEOUT_CYCLES, 4096, busy-wait watchdog limit.
- BASE_PORT, 16'd5000, destination UDP port of channel 0; channel i uses BASE_PORT+i.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  when low, no new grants are issued; an in-flight packet still completes.
- ch_req  in  NUM_CH  per-channel packet request; held until the matching ch_done.
- ch_len  in  NUM_CH*16  per-channel payload length in bytes; slice i = [16i+15:16i].
- ch_data  in  NUM_CH*DATA_WIDTH  per-channel payload word.
- ch_grant  out  NUM_CH  one-hot; the channel that currently owns the stack.
- ch_done  out  NUM_CH  one-cycle pulse when the channel's packet finishes or is rejected.
- stk_app_data  out  DATA_WIDTH  data to the stack.
- stk_app_len  out  16  latched payload length.
- stk_app_valid  out  1  packet start request to the stack.
- stk_app_ready  in  1  stack idle/ready.
- stk_dst_port  out  16  destination port of the granted channel.
- len_err  out  1  one-cycle pulse when a request is rejected for its length.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset.
- pkt_count  out  32  count of packets successfully handed to the stack; wraps.

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE, all outputs 0, pointer last=NUM_CH-1 (so channel 0 wins first), watchdog=0.
  - Reset mid-packet aborts immediately: grant drops and no ch_done is issued.
- States: IDLE, LAUNCH, BUSY, DONE, REJECT.
- IDLE:
  - If enable && |ch_req, pick the first requesting channel searching last+1, last+2, … modulo NUM_CH.
  - Register idx, ch_grant[idx]=1, len_q=ch_len[idx], stk_dst_port=BASE_PORT+idx.
  - If len_q==0 or len_q>MAX_LEN, next state is REJECT; otherwise LAUNCH.
  - Request-to-grant latency is 1 cycle.
- LAUNCH:
  - stk_app_valid=1 (registered, asserted the same cycle grant is visible).
  - On stk_app_valid && stk_app_ready at a clock edge: drop stk_app_valid, clear watchdog, go BUSY.
  - Waits in LAUNCH indefinitely if the stack is not ready.
- BUSY:
  - Watchdog increments every cycle.
  - When stk_app_ready==1, go DONE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 first: set timeout_err, go DONE.
- DONE (1 cycle):
  - ch_done[idx]=1, last=idx, grant cleared.
  - pkt_count+=1 only if no timeout occurred on this packet.
  - Next state IDLE.
  - Back-to-back packets have a minimum of 1 IDLE cycle between DONE and the next LAUNCH.
- REJECT (1 cycle):
  - ch_done[idx]=1, len_err=1, last=idx, no stack transaction; next state IDLE.
- Data mux:
  - stk_app_data = ch_data slice idx while state is LAUNCH or BUSY, else 0.
  - stk_app_len = len_q while in LAUNCH or BUSY, else 0.
- Requests:
  - Deassertion of ch_req by the granted channel after the grant is ignored; the packet runs to completion.
  - Requests arriving during non-IDLE states wait for the next IDLE.
- enable:
  - Falling during LAUNCH does not cancel the handshake.
  - Only gates the arbitration decision in IDLE.
- Fairness: with all channels requesting, the grant order is 0,1,2,3,0,… and no channel waits more than NUM_CH-1 packets.

Test Plan:
1. Reset, ch_req=4'b0001, ch_len[0]=256, stack ready → grant 0001 after 1 cycle, stk_app_valid 1 cycle, stk_dst_port=5000, stk_app_len=256, then ch_done[0] pulse and pkt_count=1.
2. ch_req=4'b1111 held, lengths 64 → grant order 0,1,2,3,0; pkt_count=5 after 5 ch_done pulses; each stk_dst_port is 5000+idx.
3. Fake stack: app_ready held low 10 cycles during LAUNCH → stk_app_valid stays high and stk_app_len stable, no ch_done until the handshake.
4. ch_len[2]=0, then ch_len[2]=1500, requesting alone → two REJECT cycles, each with ch_done[2] and len_err; stk_app_valid never asserts; pkt_count unchanged.
5. TIMEOUT_CYCLES=16, stack never returns ready after the handshake → timeout_err set at cycle 16 of BUSY, ch_done pulses, pkt_count unchanged, next request is served.
6. Reset asserted in BUSY → all outputs 0 next cycle, no ch_done; with channel 2 requesting after release, grant goes to channel 2 and pointer restarts at NUM_CH-1.

Source files
------------

// File: rtl/udp_stream_scheduler_if.sv
// Bundle of the per-channel packetiser signals and the UDP/IP stack app-side handshake.
// master: the scheduler side; slave: the packetisers plus the stack.
interface udp_stream_scheduler_if #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_CH-1:0]            ch_req;
    logic [NUM_CH*16-1:0]         ch_len;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_grant;
    logic [NUM_CH-1:0]            ch_done;
    logic [DATA_WIDTH-1:0]        stk_app_data;
    logic [15:0]                  stk_app_len;
    logic                         stk_app_valid;
    logic                         stk_app_ready;
    logic [15:0]                  stk_dst_port;

    modport master (
        input  ch_req, ch_len, ch_data, stk_app_ready,
        output ch_grant, ch_done, stk_app_data, stk_app_len, stk_app_valid, stk_dst_port
    );

    modport slave (
        output ch_req, ch_len, ch_data, stk_app_ready,
        input  ch_grant, ch_done, stk_app_data, stk_app_len, stk_app_valid, stk_dst_port
    );
endinterface

// File: rtl/udp_stream_scheduler.sv
// Round-robin scheduler sharing one UDP/IPv4 transmit stack between NUM_CH stream sources.
// One packet at a time: arbitrate, launch on app_valid/app_ready, wait for stack idle, release.
module udp_stream_scheduler #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_LEN        = 1472,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [15:0] BASE_PORT      = 16'd5000
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_enable,
    udp_stream_scheduler_if.master         io_bus,
    output logic                           o_len_err,
    output logic                           o_timeout_err,
    output logic [31:0]                    o_pkt_count
);

    localparam int unsigned IdxW   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WdW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [16:0] MaxLen = 17'(MAX_LEN);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StBusy,
        StDone,
        StReject
    } state_e;

    state_e            r_state, w_state_d;
    logic [IdxW-1:0]   r_idx, w_idx_d;
    logic [IdxW-1:0]   r_last, w_last_d;
    logic [15:0]       r_len, w_len_d;
    logic [15:0]       r_port, w_port_d;
    logic [WdW-1:0]    r_wd, w_wd_d;
    logic              r_to_pkt, w_to_pkt_d;
    logic              r_to_err, w_to_err_d;
    logic [31:0]       r_cnt, w_cnt_d;

    logic              w_found;
    logic [IdxW-1:0]   w_pick;
    logic [IdxW-1:0]   w_cand;
    logic [15:0]       w_req_len;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_active;

    // Rotating priority: first requester after the last served channel.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            w_cand = IdxW'((32'(r_last) + k) % NUM_CH);
            if (!w_found && io_bus.ch_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
        w_req_len = io_bus.ch_len[32'(w_pick)*16 +: 16];
    end

    always_comb begin
        w_state_d  = r_state;
        w_idx_d    = r_idx;
        w_last_d   = r_last;
        w_len_d    = r_len;
        w_port_d   = r_port;
        w_wd_d     = r_wd;
        w_to_pkt_d = r_to_pkt;
        w_to_err_d = r_to_err;
        w_cnt_d    = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_enable && w_found) begin
                    w_idx_d    = w_pick;
                    w_len_d    = w_req_len;
                    w_port_d   = BASE_PORT + 16'(w_pick);
                    w_to_pkt_d = 1'b0;
                    if (w_req_len == 16'd0 || {1'b0, w_req_len} > MaxLen) begin
                        w_state_d = StReject;
                    end else begin
                        w_state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                if (io_bus.stk_app_ready) begin
                    w_wd_d    = '0;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                if (io_bus.stk_app_ready) begin
                    w_state_d = StDone;
                end else if (r_wd == WdLast) begin
                    w_to_err_d = 1'b1;
                    w_to_pkt_d = 1'b1;
                    w_state_d  = StDone;
                end else begin
                    w_wd_d = r_wd + 1'b1;
                end
            end
            StDone: begin
                w_last_d = r_idx;
                w_len_d  = '0;
                w_port_d = '0;
                if (!r_to_pkt) begin
                    w_cnt_d = r_cnt + 32'd1;
                end
                w_state_d = StIdle;
            end
            StReject: begin
                w_last_d  = r_idx;
                w_len_d   = '0;
                w_port_d  = '0;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_last   <= IdxW'(NUM_CH - 1);
            r_len    <= '0;
            r_port   <= '0;
            r_wd     <= '0;
            r_to_pkt <= 1'b0;
            r_to_err <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_idx    <= w_idx_d;
            r_last   <= w_last_d;
            r_len    <= w_len_d;
            r_port   <= w_port_d;
            r_wd     <= w_wd_d;
            r_to_pkt <= w_to_pkt_d;
            r_to_err <= w_to_err_d;
            r_cnt    <= w_cnt_d;
        end
    end

    // Grant is held through the stack transaction and the reject cycle, dropped in DONE.
    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
        w_active        = (r_state == StLaunch) || (r_state == StBusy);

        io_bus.ch_grant = (w_active || r_state == StReject) ? w_onehot : '0;
        io_bus.ch_done  = (r_state == StDone || r_state == StReject) ? w_onehot : '0;
        io_bus.stk_app_valid = (r_state == StLaunch);
        io_bus.stk_app_len   = w_active ? r_len : 16'd0;
        io_bus.stk_app_data  = w_active ? io_bus.ch_data[32'(r_idx)*DATA_WIDTH +: DATA_WIDTH]
                                        : '0;
        io_bus.stk_dst_port  = r_port;

        o_len_err     = (r_state == StReject);
        o_timeout_err = r_to_err;
        o_pkt_count   = r_cnt;
    end

endmodule
